// File: rtl/mash_dac_pkg.sv
// Shared types and helpers for the multi-level DAC back end: state encoding,
// level clamping, pointer arithmetic and width helpers.
package mash_dac_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dac_state_e;

   localparam int DFLT_DAC_BW   = 4;
   localparam int DFLT_NUM_ELEM = 3;

   function automatic int level_width(input int num_elem);
      return $clog2(num_elem + 1);
   endfunction

   function automatic int ptr_width(input int num_elem);
      return (num_elem > 1) ? $clog2(num_elem) : 1;
   endfunction

   localparam int LVL_W = level_width(DFLT_NUM_ELEM);
   localparam int PTR_W = ptr_width(DFLT_NUM_ELEM);

   // Saturate a signed offset code into the legal element-count range.
   function automatic int clamp_level(input int raw, input int num_elem);
      if (raw < 0)
         return 0;
      else if (raw > num_elem)
         return num_elem;
      else
         return raw;
   endfunction

   function automatic logic level_clipped(input int raw, input int num_elem);
      return (raw < 0) || (raw > num_elem);
   endfunction

   function automatic int ptr_add(input int ptr, input int lvl, input int num_elem);
      return (ptr + lvl) % num_elem;
   endfunction

endpackage

// File: rtl/dwa_rotate_mask.sv
// Wrap-around thermometer mask: 'level' consecutive ones starting at bit 'ptr',
// wrapping modulo NUM_ELEM. With ptr = 0 this is a plain thermometer code.
module dwa_rotate_mask
   import mash_dac_pkg::*;
#(
   parameter int NUM_ELEM = DFLT_NUM_ELEM,
   parameter int LVL_W    = level_width(NUM_ELEM),
   parameter int PTR_W    = ptr_width(NUM_ELEM)
) (
   input  logic [LVL_W-1:0]    level,
   input  logic [PTR_W-1:0]    ptr,
   output logic [NUM_ELEM-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         mask[i] = (((i + NUM_ELEM - int'(ptr)) % NUM_ELEM) < int'(level));
      end
   end

endmodule

// File: rtl/axis_dwa_driver.sv
// AXI-Stream sink that turns signed modulator codes into registered unit-element
// enables, using data-weighted averaging or a static thermometer map.
module axis_dwa_driver
   import mash_dac_pkg::*;
#(
   parameter int DAC_BW       = DFLT_DAC_BW,
   parameter int NUM_ELEM     = DFLT_NUM_ELEM,
   parameter int OFFSET       = 1,
   parameter int IDLE_TIMEOUT = 16,
   localparam int PW          = ptr_width(NUM_ELEM)
) (
   input  logic                aclk,
   input  logic                arst_n,
   input  logic [DAC_BW-1:0]   s_axis_data_tdata,
   input  logic                s_axis_data_tvalid,
   output logic                s_axis_data_tready,
   input  logic                dwa_en,
   output logic [NUM_ELEM-1:0] m_elem,
   output logic                m_elem_valid,
   output logic                clip_flag,
   output logic [PW-1:0]       dwa_ptr
);

   localparam int LW = level_width(NUM_ELEM);
   localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [NUM_ELEM-1:0] IDLE_PAT = NUM_ELEM'((64'd1 << OFFSET) - 64'd1);

   dac_state_e            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_ELEM-1:0]   m_elem_q, m_elem_d;
   logic                  valid_q, valid_d;
   logic                  clip_q, clip_d;
   logic [PW-1:0]         ptr_q, ptr_d;
   logic                  ready_q;

   logic                  accept;
   logic                  timeout_hit;
   logic signed [DAC_BW+1:0] code_ext;
   int                    code_raw;
   logic [LW-1:0]         level;
   logic                  clip_in;
   logic [PW-1:0]         rot_ptr;
   logic [PW-1:0]         ptr_adv;
   logic [NUM_ELEM-1:0]   mask;

   assign accept   = s_axis_data_tvalid && ready_q;
   assign code_ext = $signed({{2{s_axis_data_tdata[DAC_BW-1]}}, s_axis_data_tdata})
                     + $signed((DAC_BW+2)'(OFFSET));
   assign code_raw = int'(code_ext);
   assign level    = LW'(clamp_level(code_raw, NUM_ELEM));
   assign clip_in  = level_clipped(code_raw, NUM_ELEM);
   assign rot_ptr  = dwa_en ? ptr_q : '0;
   assign ptr_adv  = PW'(ptr_add(int'(ptr_q), int'(level), NUM_ELEM));

   // The last tolerated silent cycle in RUN; the following edge drops to IDLE.
   assign timeout_hit = (IDLE_TIMEOUT != 0) && (state_q == ST_RUN) && !accept
                        && (cnt_q == CW'(IDLE_TIMEOUT - 1));

   dwa_rotate_mask #(
      .NUM_ELEM (NUM_ELEM),
      .LVL_W    (LW),
      .PTR_W    (PW)
   ) u_rotate (
      .level (level),
      .ptr   (rot_ptr),
      .mask  (mask)
   );

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         m_elem_q <= IDLE_PAT;
         valid_q  <= 1'b0;
         clip_q   <= 1'b0;
         ptr_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         m_elem_q <= m_elem_d;
         valid_q  <= valid_d;
         clip_q   <= clip_d;
         ptr_q    <= ptr_d;
         ready_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (timeout_hit) begin
               state_d = ST_IDLE;
            end else if (!accept) begin
               if (IDLE_TIMEOUT != 0 || cnt_q != '1)
                  cnt_d = cnt_q + CW'(1);
               else
                  cnt_d = cnt_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Zero-order hold on m_elem between accepts; the pointer only moves in DWA mode.
   always_comb begin
      m_elem_d = m_elem_q;
      valid_d  = 1'b0;
      clip_d   = clip_q;
      ptr_d    = dwa_en ? ptr_q : '0;
      if (accept) begin
         m_elem_d = mask;
         valid_d  = 1'b1;
         clip_d   = clip_q | clip_in;
         if (dwa_en) ptr_d = ptr_adv;
      end else if (timeout_hit) begin
         m_elem_d = IDLE_PAT;
      end
   end

   assign s_axis_data_tready = ready_q;
   assign m_elem             = m_elem_q;
   assign m_elem_valid       = valid_q;
   assign clip_flag          = clip_q;
   assign dwa_ptr            = ptr_q;

endmodule

// File: doc/axis_dwa_driver.md
Name: axis_dwa_driver

Overview:
- Downstream consumer of the MASH 1-1 modulator's signed multi-level AXI-Stream output.
- Maps each signed code to a unit-element count (thermometer level).
- Selects which unit DAC elements to drive using data-weighted averaging (DWA), a rotating pointer that spreads element mismatch. Static thermometer mapping is also supported.
- Registered element enables feed the output pads or the unit-cell DAC directly.

Parameters:
- DAC_BW, 4: width of signed input code (two's complement).
- NUM_ELEM, 3: number of unit DAC elements.
- OFFSET, 1: added to input code to form level. Code -OFFSET maps to 0 elements.
- IDLE_TIMEOUT, 16: consecutive no-accept cycles in RUN before falling back to IDLE. 0 disables timeout.

Ports:
- aclk  input  1  clock
- arst_n  input  1  reset, synchronous, active-low
- s_axis_data_tdata  input  DAC_BW  signed modulator code
- s_axis_data_tvalid  input  1  code valid
- s_axis_data_tready  output  1  always 1 out of reset, 0 during reset
- dwa_en  input  1  1 = DWA rotation, 0 = static thermometer (quasi-static config)
- m_elem  output  NUM_ELEM  unit element enables, bit i drives element i
- m_elem_valid  output  1  m_elem updated from an accepted code this cycle
- clip_flag  output  1  sticky: an input code was out of range
- dwa_ptr  output  clog2(NUM_ELEM)  current rotation pointer (debug)

Behaviour:
- Clock and reset: reset arst_n, synchronous, active-low; clock aclk.
- Reset values: m_elem = idle pattern (bits [OFFSET-1:0] set, rest 0); m_elem_valid = 0; clip_flag = 0; dwa_ptr = 0; state = IDLE; timeout counter = 0.
- Accept: accept = s_axis_data_tvalid && s_axis_data_tready.
- Level computation:
  - Sign-extend tdata to DAC_BW+2 bits, then add OFFSET.
  - If the result is < 0, level = 0 and clip_flag is set. If > NUM_ELEM, level = NUM_ELEM and clip_flag is set.
  - clip_flag clears only on reset.
- Element selection, DWA mode (dwa_en = 1):
  - mask = level consecutive ones starting at bit dwa_ptr, wrapping modulo NUM_ELEM.
  - ptr_next = (dwa_ptr + level) mod NUM_ELEM.
  - level = NUM_ELEM gives all ones with the pointer unchanged. level = 0 gives all zeros with the pointer unchanged.
- Element selection, static mode (dwa_en = 0): mask = bits [level-1:0] set; dwa_ptr forced to 0 on every clock.
- Latency: one cycle. mask is registered into m_elem at the accept edge; m_elem_valid = 1 for that cycle only.
- State machine (IDLE, RUN):
  - IDLE: m_elem = idle pattern. Any accept writes the mask and moves to RUN.
  - RUN: on accept, update m_elem and clear the counter. On no accept, m_elem holds its last value (zero-order hold), m_elem_valid = 0, and the counter increments.
  - If IDLE_TIMEOUT != 0 and the counter equals IDLE_TIMEOUT-1 with no accept, the next edge enters IDLE and loads the idle pattern. dwa_ptr is held.
  - Counter saturates when IDLE_TIMEOUT = 0.
- dwa_en change mid-stream: takes effect on the next accept. The pointer zeroes on the first edge with dwa_en = 0.
- Reset mid-operation: all state returns to reset values on that edge. An accept coincident with reset is dropped.

Decomposition:
- mash_dac_pkg holds:
  - state enum typedef (IDLE, RUN);
  - function for level clamp;
  - function for modulo pointer add;
  - localparams for level and pointer widths.
- One combinational sub-module, dwa_rotate_mask: inputs level and ptr, output NUM_ELEM wrap-around mask. It is instantiated once and unit-testable separately.

Test Plan:
- Reset: hold arst_n = 0 for 3 cycles, then release -> m_elem = 3'b001, m_elem_valid = 0, clip_flag = 0, dwa_ptr = 0, tready = 1.
- DWA: dwa_en = 1, back-to-back codes 1, 1, 0, -1, 2 -> m_elem 011, 101, 010, 000, 111; dwa_ptr 2, 1, 2, 2, 2; m_elem_valid high on each of the 5 cycles.
- Static: dwa_en = 0, same codes -> m_elem 011, 011, 001, 000, 111; dwa_ptr stays 0.
- Clipping: code -2 (4'b1110) -> m_elem = 000 and clip_flag = 1. Then code 3 -> m_elem = 111, and clip_flag stays 1 through further in-range codes.
- Idle timeout: IDLE_TIMEOUT = 4, accept code 1 (m_elem 011), then tvalid = 0 for 5 cycles:
  - m_elem holds 011 for 3 edges and becomes 001 on the 4th;
  - dwa_ptr is unchanged;
  - the next code 0 gives m_elem 100 (ptr 2).
- Reset mid-stream: assert reset together with tvalid and code 2 after ptr = 1 -> code dropped, all outputs at reset values the next cycle.
